// File: rtl/reg_sweeper_pkg.sv
// Shared definitions for the register sweeper.
// Holds the FSM state encoding and the direction constants used by the
// top level and by the register step helper.
package reg_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FIN   = 2'd2
    } state_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/reg_sweeper_step.sv
// reg_step: combinational next-register computation.
// Steps a register number by +1 (dir=DIR_UP) or -1 (dir=DIR_DOWN), modulo
// 2^REG_BITS. With SKIP_ZERO set, a result of 0 is stepped once more, so
// register 0 can never be produced.
// Ports:
//   cur_reg  in  REG_BITS  register to step from
//   dir      in  1         step direction
//   next_reg out REG_BITS  stepped register
module reg_step
    import reg_sweeper_pkg::*;
#(
    parameter int REG_BITS  = 5,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic [REG_BITS-1:0] cur_reg,
    input  logic                dir,
    output logic [REG_BITS-1:0] next_reg
);

    logic [REG_BITS-1:0] once;

    always_comb begin
        once     = (dir == DIR_UP) ? cur_reg + 1'b1 : cur_reg - 1'b1;
        next_reg = once;
        // Landing on 0 only happens from the top (up) or from 1 (down);
        // one further step lands on 1 or on the all-ones register.
        if (SKIP_ZERO && (once == '0)) begin
            next_reg = (dir == DIR_UP) ? once + 1'b1 : once - 1'b1;
        end
    end

endmodule

// File: rtl/reg_sweeper.sv
// reg_sweeper: multi-register write sequencer.
// A go pulse in IDLE latches start register, count and direction, then one
// register number per non-stalled cycle is presented with wr_en until the
// count is exhausted or abort arrives; a one-cycle done pulse follows.
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   go         in   start request, sampled in IDLE only
//   abort      in   ends an active run; suppresses go in IDLE
//   direction  in   0 = down, 1 = up (latched at start)
//   start_reg  in   first register of the run (latched at start)
//   count      in   number of writes (latched at start)
//   stall      in   hold the current register, no write this cycle
//   regnum     out  register being written
//   wr_en      out  register file write enable
//   busy       out  high while writing
//   done       out  one-cycle completion pulse
//   aborted    out  with done: the run ended by abort
module reg_sweeper
    import reg_sweeper_pkg::*;
#(
    parameter int REG_BITS   = 5,
    parameter int COUNT_BITS = 6,
    parameter bit SKIP_ZERO  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  abort,
    input  logic                  direction,
    input  logic [REG_BITS-1:0]   start_reg,
    input  logic [COUNT_BITS-1:0] count,
    input  logic                  stall,
    output logic [REG_BITS-1:0]   regnum,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    state_e                state_q, state_d;
    logic [REG_BITS-1:0]   cur_q, cur_d;
    logic [COUNT_BITS-1:0] rem_q, rem_d;
    logic                  dir_q, dir_d;
    logic                  aborted_q, aborted_d;

    logic [REG_BITS-1:0]   start_stepped;
    logic [REG_BITS-1:0]   start_eff;
    logic [REG_BITS-1:0]   cur_stepped;

    // Start register nudged off 0 when register 0 is excluded.
    reg_step #(
        .REG_BITS  (REG_BITS),
        .SKIP_ZERO (SKIP_ZERO)
    ) u_step_start (
        .cur_reg  (start_reg),
        .dir      (direction),
        .next_reg (start_stepped)
    );

    // Advance of the current register during the run.
    reg_step #(
        .REG_BITS  (REG_BITS),
        .SKIP_ZERO (SKIP_ZERO)
    ) u_step_run (
        .cur_reg  (cur_q),
        .dir      (dir_q),
        .next_reg (cur_stepped)
    );

    assign start_eff = (SKIP_ZERO && (start_reg == '0)) ? start_stepped : start_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            rem_q     <= '0;
            dir_q     <= DIR_DOWN;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        aborted_d = aborted_q;

        case (state_q)
            ST_IDLE: begin
                if (go && !abort) begin
                    dir_d     = direction;
                    rem_d     = count;
                    cur_d     = start_eff;
                    aborted_d = 1'b0;
                    state_d   = (count != '0) ? ST_WRITE : ST_FIN;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_FIN;
                end else if (!stall) begin
                    rem_d = rem_q - 1'b1;
                    // The last write leaves the register in place so that
                    // regnum shows the last written register during FIN.
                    if (rem_q == COUNT_BITS'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        cur_d = cur_stepped;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign regnum  = cur_q;
    assign busy    = (state_q == ST_WRITE);
    assign wr_en   = busy & ~stall & ~abort;
    assign done    = (state_q == ST_FIN);
    assign aborted = done & aborted_q;

endmodule

// File: tb/tb_reg_sweeper.sv
// Randomised self-checking bench for reg_sweeper (REG_BITS=5, COUNT_BITS=6,
// SKIP_ZERO=1). A small register file sits on the DUT outputs; the
// reference derives the expected register list of each run arithmetically
// and tracks the expected register file contents.
module tb_reg_sweeper;

    localparam int NREG = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        go;
    logic        abort;
    logic        direction;
    logic [4:0]  start_reg;
    logic [5:0]  count;
    logic        stall;
    logic [4:0]  regnum;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        aborted;

    logic [15:0] data;
    logic        mem_clear;
    logic [15:0] mem     [NREG];
    logic [15:0] exp_mem [NREG];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    reg_sweeper #(
        .REG_BITS   (5),
        .COUNT_BITS (6),
        .SKIP_ZERO  (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .abort     (abort),
        .direction (direction),
        .start_reg (start_reg),
        .count     (count),
        .stall     (stall),
        .regnum    (regnum),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    // Register file fed by the sweeper.
    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < NREG; i++) mem[i] <= 16'hA000 + 16'(i);
        end else if (wr_en) begin
            mem[regnum] <= data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // +/-1 modulo 32, never landing on register 0.
    function automatic int step(input int r, input bit up);
        int n;
        n = up ? (r + 1) % NREG : (r + NREG - 1) % NREG;
        if (n == 0) n = up ? 1 : NREG - 1;
        return n;
    endfunction

    function automatic int eff_start(input int s, input bit up);
        return (s == 0) ? step(0, up) : s;
    endfunction

    task automatic check_mem();
        for (int i = 0; i < NREG; i++) check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    // One run. Called at posedge+1 of an IDLE cycle; returns at posedge+1
    // of the first IDLE cycle after FIN.
    task automatic do_run(input int s, input int cnt, input bit up, input int stall_pct,
                          input int stall_at, input int abort_at, input bit go_mid,
                          input bit go_fin, input int base);
        int seq[$];
        int cur, k, cyc, nstall;
        bit ab, st, a;
        cur = eff_start(s, up);
        for (int i = 0; i < cnt; i++) begin
            seq.push_back(cur);
            cur = step(cur, up);
        end
        go = 1'b1; abort = 1'b0; stall = 1'b0;
        start_reg = 5'(s); count = 6'(cnt); direction = up;
        @(negedge clock);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_wr_en", 32'(wr_en), 0);
        @(posedge clock); #1;
        go = 1'b0;
        k = 0; cyc = 1; ab = 1'b0; nstall = 0;
        while (k < cnt && !ab) begin
            a  = (cyc == abort_at);
            st = (cyc == stall_at) || (nstall < 6 && $urandom_range(99) < stall_pct);
            if (st) nstall++;
            stall = st; abort = a;
            go = go_mid ? 1'($urandom_range(1)) : 1'b0;
            start_reg = 5'($urandom); count = 6'($urandom); direction = 1'($urandom);
            data = 16'(base + k);
            @(negedge clock);
            check("busy", 32'(busy), 1);
            check("regnum", 32'(regnum), 32'(seq[k]));
            check("wr_en", 32'(wr_en), 32'(!st && !a));
            check("done", 32'(done), 0);
            @(posedge clock); #1;
            if (a) ab = 1'b1;
            else if (!st) begin
                exp_mem[seq[k]] = 16'(base + k);
                k++;
            end
            cyc++;
        end
        stall = 1'b0; abort = 1'b0; go = go_fin; count = 6'd5; start_reg = 5'd3;
        @(negedge clock);
        check("fin_done", 32'(done), 1);
        check("fin_busy", 32'(busy), 0);
        check("fin_wr_en", 32'(wr_en), 0);
        check("fin_aborted", 32'(aborted), 32'(ab));
        if (!ab && cnt > 0) check("fin_regnum", 32'(regnum), 32'(seq[cnt-1]));
        check_mem();
        @(posedge clock); #1;
        go = 1'b0;
        $display("RUN start=%0d count=%0d dir=%0d writes=%0d stalls=%0d aborted=%0d cycles=%0d",
                 s, cnt, up, k, nstall, ab, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; mem_clear = 1'b1;
        go = 1'b0; abort = 1'b0; direction = 1'b0; start_reg = '0; count = '0;
        stall = 1'b0; data = '0;
        for (int i = 0; i < NREG; i++) exp_mem[i] = 16'hA000 + 16'(i);
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_regnum", 32'(regnum), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_aborted", 32'(aborted), 0);
        @(posedge clock); #1;
        mem_clear = 1'b0; reset = 1'b1;
        @(posedge clock); #1;

        // Directed cases
        do_run(13, 6, 1'b0, 0, -1, 0, 1'b0, 1'b0, 'hd00);
        do_run(30, 4, 1'b1, 0, -1, 0, 1'b0, 1'b1, 'h300);
        do_run(4, 3, 1'b1, 0, 2, 0, 1'b0, 1'b0, 'h400);
        do_run(20, 10, 1'b0, 0, -1, 3, 1'b1, 1'b0, 'h500);
        do_run(7, 0, 1'b1, 0, -1, 0, 1'b0, 1'b1, 'h600);
        do_run(0, 3, 1'b1, 0, -1, 0, 1'b0, 1'b0, 'h610);
        do_run(0, 2, 1'b0, 0, -1, 0, 1'b0, 1'b0, 'h620);
        do_run(2, 40, 1'b0, 0, -1, 0, 1'b1, 1'b0, 'h630);

        // abort in IDLE suppresses go
        go = 1'b1; abort = 1'b1; count = 6'd5; start_reg = 5'd9;
        @(posedge clock); #1;
        go = 1'b0; abort = 1'b0;
        @(negedge clock);
        check("idle_abort_busy", 32'(busy), 0);
        check("idle_abort_done", 32'(done), 0);
        @(posedge clock); #1;
        $display("RUN idle go with abort suppressed");

        // Reset in the middle of a run
        go = 1'b1; start_reg = 5'd9; count = 6'd20; direction = 1'b1;
        @(posedge clock); #1;
        go = 1'b0;
        for (int c = 0; c < 2; c++) begin
            data = 16'h700 + 16'(c);
            @(posedge clock); #1;
            exp_mem[9 + c] = 16'h700 + 16'(c);
        end
        data = 16'h7ff;
        #1 reset = 1'b0;
        #1;
        check("mid_rst_regnum", 32'(regnum), 0);
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_aborted", 32'(aborted), 0);
        repeat (3) begin
            @(negedge clock);
            check("in_rst_wr_en", 32'(wr_en), 0);
        end
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;
        $display("RUN reset mid-run after 2 writes");
        do_run(5, 5, 1'b1, 0, -1, 0, 1'b0, 1'b0, 'h800);

        // Randomised runs
        for (int r = 0; r < 25; r++) begin
            int s, cnt, ab_at;
            s     = $urandom_range(NREG - 1);
            cnt   = ($urandom_range(5) == 0) ? $urandom_range(63, 33) : $urandom_range(20);
            ab_at = (cnt > 0 && $urandom_range(4) == 0) ? $urandom_range(cnt, 1) : 0;
            do_run(s, cnt, 1'($urandom_range(1)), 20, -1, ab_at,
                   1'($urandom_range(1)), 1'($urandom_range(1)), 'h1000 + r * 'h100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_sweeper.md
# reg_sweeper

Parametrised multi-register write sequencer for the lab datapath. On a `go` pulse it emits a run of `count` consecutive register numbers, starting at `start_reg` and stepping up or down. It asserts a write enable for each one so a register file can take successive `data` words. It adds programmable start and length, wrap-around, optional skipping of register 0, write stall and abort, and a one-cycle completion pulse.

## Interface
- `REG_BITS`, default 5: width of register numbers; the register space is 2^REG_BITS entries.
- `COUNT_BITS`, default 6: width of the `count` input; the maximum run is 2^COUNT_BITS−1 writes.
- `SKIP_ZERO`, default 1: when 1, register 0 is never emitted; the sequence steps over it.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `go` in 1: start request; sampled only in IDLE.
- `abort` in 1: terminates an active run.
- `direction` in 1: 0 = down (decrement), 1 = up (increment); latched at start.
- `start_reg` in REG_BITS: first register of the run; latched at start.
- `count` in COUNT_BITS: number of writes; latched at start.
- `stall` in 1: when 1, the current register is held and not counted.
- `regnum` out REG_BITS: register being written.
- `wr_en` out 1: write enable to the register file.
- `busy` out 1: high in WRITE state.
- `done` out 1: one-cycle pulse after the run ends, whether it completed or was aborted.
- `aborted` out 1: valid with `done`; 1 if the run ended by `abort`.

## Operation
- States: IDLE, WRITE, FIN.
- **IDLE:**
  - On `go`=1 and `abort`=0: latch `direction`, `count` and the effective start register into internal state.
  - The effective start register is `start_reg`, except when SKIP_ZERO=1 and `start_reg`=0; then the step function is applied once.
  - If the latched count ≠ 0, go to WRITE; if it is 0, go to FIN.
- **WRITE:**
  - `wr_en` = ~`stall`; `regnum` = current register.
  - On a non-stalled cycle: decrement the remaining count and advance the register.
  - When the remaining count reaches 0, go to FIN.
- **FIN:** `done`=1 for one cycle, then return to IDLE. `regnum` holds the last written value.
- **Step function:** ±1 modulo 2^REG_BITS, so 31→0 going up and 0→31 going down. With SKIP_ZERO=1, a result of 0 is stepped once more (31→1 up, 1→31 down).
- **`abort` in WRITE:** takes priority over `stall` and the count. `wr_en` is forced to 0 that cycle, the block goes to FIN, and `aborted` is set.
- **`abort` in IDLE:** suppresses `go`.
- **`go` while busy or in FIN:** ignored; it is not queued.
- **Run length:** a count larger than the register space wraps, so registers are rewritten; the block does no range checking.
- **Reset mid-run:** returns immediately to IDLE. All outputs go to 0 and no further writes occur.

## Timing
- Reset values: `regnum`=0, `wr_en`=0, `busy`=0, `done`=0, `aborted`=0. State is IDLE.
- Outputs are registered state decoded combinationally; `wr_en` is combinational in `stall` and `abort`.
- **Latency with no stalls:**
  - `go` sampled at edge 0.
  - `wr_en` is high in cycles 1..count.
  - `done` is high in cycle count+1.
  - The block accepts a new `go` at the edge ending cycle count+1 + 1, i.e. the first IDLE cycle.
- Each stalled cycle extends the run by exactly one cycle.
- With count=0: `done` is high in cycle 1 and `wr_en` is never asserted.
- The register file writes `data` at the same edge at which `regnum` advances.

## Structure
- Shared package `reg_sweeper_pkg`:
  - state encoding (IDLE=2'd0, WRITE=2'd1, FIN=2'd2);
  - direction constants DIR_DOWN=0, DIR_UP=1.
- Sub-module `reg_step`: combinational next-register computation, parameterised by REG_BITS and SKIP_ZERO. Used both for the effective start register and for advancing during the run.
- Top level contains the FSM, the remaining-count down-counter and the output decode.

## Test plan
- **Down run:** start_reg=13, count=6, direction=0, no stall → writes to 13,12,11,10,9,8 carry data 0xd00..0xd05; `done` pulses in cycle 7; r7 and r14 are untouched.
- **Up run with wrap, SKIP_ZERO=1:** start_reg=30, count=4, direction=1 → regnum sequence 30,31,1,2; r0 is never written.
- **Stall:** start_reg=4, count=3, up, `stall` high in cycle 2 → `wr_en` is 1,0,1,1 over cycles 1–4, regnum is 4,5,5,6, and `done` pulses in cycle 5.
- **Abort:**
  - count=10 with `abort` in cycle 3 → exactly 2 writes; `done`=1 and `aborted`=1 in cycle 4.
  - `go` during the run is ignored.
- **Count 0 and reset:**
  - count=0 → no `wr_en`; `done` pulses in cycle 1.
  - Asserting `reset` low mid-run → all outputs are 0 immediately, and a fresh `go` afterwards runs normally.
